// File: rtl/fetch_pc_ctrl.sv
// Fetch sequencer: owns PC_F, picks the next PC (sequential/branch/exception/ERET),
// drives the ROM word index and flags address errors and wrong-path kills.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter int          IM_WORDS   = 2048,
    localparam int         AW         = $clog2(IM_WORDS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          stall,
    input  logic          br_valid,
    input  logic [31:0]   br_target,
    input  logic          exc_req,
    input  logic          eret_req,
    input  logic [31:0]   epc,
    output logic [31:0]   PC_F,
    output logic [AW-1:0] im_index,
    output logic          fetch_valid,
    output logic          adel_F,
    output logic          flush_D,
    output logic [31:0]   fetch_count
);

    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, ERR = 2'd2} state_t;

    localparam logic [31:0] IM_LAST = IM_BASE + 32'(4 * IM_WORDS) - 32'd4;

    state_t      state, state_n;
    logic [31:0] pc_n;
    logic        redirect;

    assign redirect    = exc_req | eret_req;
    assign flush_D     = redirect & (state != BOOT);
    assign adel_F      = (state != BOOT) &
                         ((PC_F[1:0] != 2'b00) | (PC_F < IM_BASE) | (PC_F > IM_LAST));
    assign fetch_valid = (state == RUN) & ~adel_F;
    // Index is driven even for bad PCs; consumers qualify with fetch_valid.
    assign im_index    = AW'((PC_F - IM_BASE) >> 2);

    always_comb begin
        state_n = state;
        pc_n    = PC_F;
        unique case (state)
            BOOT: state_n = RUN;
            RUN, ERR: begin
                if (exc_req) begin
                    pc_n    = EXC_VECTOR;
                    state_n = RUN;
                end else if (eret_req) begin
                    pc_n    = epc;
                    state_n = RUN;
                end else if (state == RUN && !stall) begin
                    // A bad PC parks the fetcher until CP0 redirects it.
                    if (adel_F)        state_n = ERR;
                    else if (br_valid) pc_n    = br_target;
                    else               pc_n    = PC_F + 32'd4;
                end
            end
            default: state_n = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= BOOT;
            PC_F        <= RESET_PC;
            fetch_count <= '0;
        end else begin
            state <= state_n;
            PC_F  <= pc_n;
            if (fetch_valid && !stall && !flush_D)
                fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: directed scenarios then random traffic,
// each cycle's expected outputs come from a behavioural model of the fetch rules.
module tb_fetch_pc_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] VEC    = 32'h0000_4180;
    localparam logic [31:0] BASE   = 32'h0000_3000;
    localparam int          WORDS  = 2048;
    localparam int          AW     = 11;

    logic          clk = 1'b0, reset_n = 1'b0;
    logic          stall = 1'b0, br_valid = 1'b0, exc_req = 1'b0, eret_req = 1'b0;
    logic [31:0]   br_target = '0, epc = '0;
    logic [31:0]   PC_F, fetch_count;
    logic [AW-1:0] im_index;
    logic          fetch_valid, adel_F, flush_D;

    fetch_pc_ctrl dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .br_valid(br_valid),
        .br_target(br_target), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
        .PC_F(PC_F), .im_index(im_index), .fetch_valid(fetch_valid),
        .adel_F(adel_F), .flush_D(flush_D), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] idx;
        logic        fv;
        logic        adel;
        logic        flush;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_pass = 0;

    // Model: mode 0 = first cycle after reset, 1 = fetching, 2 = parked on bad PC.
    int          m_mode;
    logic [31:0] m_pc, m_cnt;

    function automatic bit bad_addr(input logic [31:0] pc);
        longint p = longint'(pc);
        return (p % 4 != 0) || (p < longint'(BASE)) || (p >= longint'(BASE) + 4 * WORDS);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    endtask

    function automatic exp_t expect_now(input bit e, input bit r);
        exp_t        x;
        logic [31:0] off = m_pc - BASE;
        x.pc    = m_pc;
        x.idx   = (off / 4) % WORDS;
        x.adel  = (m_mode != 0) && bad_addr(m_pc);
        x.fv    = (m_mode == 1) && !x.adel;
        x.flush = (m_mode != 0) && (e || r);
        x.cnt   = m_cnt;
        return x;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_pc   = RST_PC;
        m_cnt  = 0;
    endtask

    task automatic step(input bit s, input bit b, input logic [31:0] t,
                        input bit e, input bit r, input logic [31:0] ep);
        exp_t x;
        @(negedge clk);
        reset_n = 1'b1; stall = s; br_valid = b; br_target = t;
        exc_req = e; eret_req = r; epc = ep;
        x = expect_now(e, r);
        q.push_back(x);
        if (x.fv && !s && !x.flush) m_cnt = m_cnt + 1;
        if (m_mode == 0) m_mode = 1;
        else if (e) begin m_pc = VEC; m_mode = 1; end
        else if (r) begin m_pc = ep;  m_mode = 1; end
        else if (m_mode == 1 && !s) begin
            if (x.adel)   m_mode = 2;
            else if (b)   m_pc = t;
            else          m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset_n = 1'b0; stall = 0; br_valid = 0; exc_req = 0; eret_req = 0;
            #1;
            model_reset();
            q.push_back(expect_now(0, 0));
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int k = $urandom_range(0, 9);
        if (k < 7)  return BASE + 32'(4 * $urandom_range(0, WORDS - 1));
        if (k == 7) return BASE + 32'($urandom_range(0, 4 * WORDS - 1)) | 32'd1;
        if (k == 8) return $urandom;
        return ($urandom_range(0, 1) != 0) ? 32'h0000_4FFC : 32'h0000_2FFC;
    endfunction

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                x = q.pop_front();
                chk("PC_F", PC_F, x.pc);
                chk("im_index", 32'(im_index), x.idx);
                chk("fetch_valid", 32'(fetch_valid), 32'(x.fv));
                chk("adel_F", 32'(adel_F), 32'(x.adel));
                chk("flush_D", 32'(flush_D), 32'(x.flush));
                chk("fetch_count", fetch_count, x.cnt);
            end
        end
    end

    initial begin : driver
        model_reset();
        do_reset(2);
        idle(3);                                  // BOOT, 0x3000, 0x3004
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);  // stall at 0x3008
        idle(2);
        step(0, 1, 32'h3100, 0, 0, 0);            // taken branch
        step(1, 1, 32'h3200, 0, 0, 0);            // stalled branch dropped
        idle(1);
        step(0, 1, 32'h3020, 0, 0, 0);
        step(1, 1, 32'h3200, 1, 0, 0);            // exception beats stall and branch
        idle(2);
        step(0, 1, 32'h3102, 0, 0, 0);            // misaligned target
        idle(2);
        step(0, 1, 32'h3200, 0, 0, 0);            // branch ignored while parked
        step(1, 0, 0, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 1, 0, 0);                   // exception leaves parked state
        idle(1);
        step(0, 1, 32'h3001, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);                   // bad PC with stall stays fetching
        idle(2);
        step(0, 0, 0, 0, 1, 32'h3050);            // ERET leaves parked state
        step(0, 1, 32'h5000, 0, 0, 0);            // above ROM
        idle(2);
        step(0, 0, 0, 0, 1, 32'h4FFC);            // last legal word, then falls off
        idle(3);
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 32'h2FFC, 0, 0, 0);            // below ROM
        idle(2);
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 32'h3040, 0, 0, 0);
        idle(1);
        do_reset(1);                              // asynchronous reset mid-run
        step(0, 0, 0, 1, 1, 32'h3400);            // redirects ignored in BOOT
        idle(2);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 2));
            else step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, rand_addr(),
                      $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, rand_addr());
        end
        repeat (2) @(negedge clk);
        #3;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
